ring_slot_arbiter: RTL and testbench

//  Per-core ring stop between the ring and the local I/O units (barrier, messenger, lock unit, etc.).

---
 rtl/ring_slot_arbiter.sv | 137 +++++++++++++
 tb/tb_ring_slot_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/ring_slot_arbiter.sv
// rtl/ring_slot_arbiter.sv - per-core ring stop: strips own slots, captures and grants the Token round-robin
module ring_slot_arbiter #(
   parameter int NREQ   = 4,
   parameter int RING_W = 32
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [3:0]             whichCore,
   input  logic [RING_W-1:0]      RingIn,
   input  logic [3:0]             SlotTypeIn,
   input  logic [3:0]             SourceIn,
   output logic [RING_W-1:0]      RingOut,
   output logic [3:0]             SlotTypeOut,
   output logic [3:0]             SourceOut,
   input  logic [NREQ-1:0]        reqWants,
   input  logic [NREQ-1:0]        reqDrive,
   input  logic [NREQ*RING_W-1:0] reqData,
   input  logic [NREQ*4-1:0]      reqType,
   input  logic [NREQ*4-1:0]      reqSource,
   output logic [NREQ-1:0]        reqAcquire,
   output logic                   protoErr
);

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [3:0] SLOT_TOKEN = 4'd1;
   localparam logic [3:0] SLOT_NULL  = 4'd7;
   localparam logic [PTR_W-1:0] LAST_REQ = PTR_W'(NREQ - 1);

   typedef enum logic {PASS, HOLD} state_t;

   state_t            state, nextState;
   logic [PTR_W-1:0]  rrPtr, rrPtrNext;
   logic [PTR_W-1:0]  owner, ownerNext;
   logic [PTR_W-1:0]  winner, cand, sel;
   logic              found;
   logic [RING_W-1:0] dataNext;
   logic [3:0]        typeNext, sourceNext;
   logic              protoErrNext;
   logic              tokenIn, ownReturn, foreignInHold;

   assign tokenIn   = (SlotTypeIn == SLOT_TOKEN);
   assign ownReturn = (SlotTypeIn != SLOT_TOKEN) && (SlotTypeIn != SLOT_NULL) && (SourceIn == whichCore);
   // A duplicate Token or someone else's message means another stop ignored our ownership.
   assign foreignInHold = tokenIn || ((SlotTypeIn != SLOT_NULL) && (SourceIn != whichCore));

   // Round-robin search: first wanting requester at or above rrPtr, wrapping around.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = PTR_W'((int'(rrPtr) + k) % NREQ);
         if (!found && reqWants[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   // Next-state, grant and next ring slot; the owner's slot is selected by whoever holds or is winning.
   always_comb begin
      nextState    = state;
      rrPtrNext    = rrPtr;
      ownerNext    = owner;
      dataNext     = RingIn;
      typeNext     = SlotTypeIn;
      sourceNext   = SourceIn;
      protoErrNext = protoErr;
      reqAcquire   = '0;
      sel          = (state == HOLD) ? owner : winner;

      case (state)
         PASS: begin
            if (tokenIn && found) begin
               reqAcquire[winner] = 1'b1;
               if (reqDrive[winner]) begin
                  dataNext   = reqData[sel*RING_W +: RING_W];
                  typeNext   = reqType[sel*4 +: 4];
                  sourceNext = reqSource[sel*4 +: 4];
                  rrPtrNext  = (winner == LAST_REQ) ? '0 : winner + 1'b1;
                  ownerNext  = winner;
                  nextState  = HOLD;
               end
            end else if (ownReturn) begin
               dataNext   = '0;
               typeNext   = SLOT_NULL;
               sourceNext = '0;
            end
         end
         HOLD: begin
            reqAcquire[owner] = 1'b1;
            if (reqDrive[owner]) begin
               dataNext   = reqData[sel*RING_W +: RING_W];
               typeNext   = reqType[sel*4 +: 4];
               sourceNext = reqSource[sel*4 +: 4];
            end else begin
               // Owner finished: the Token goes back out and takes precedence over stripping.
               dataNext   = '0;
               typeNext   = SLOT_TOKEN;
               sourceNext = whichCore;
               nextState  = PASS;
            end
            if (foreignInHold) begin
               protoErrNext = 1'b1;
            end
         end
         default: nextState = PASS;
      endcase

      // Nothing is granted while reset is asserted since no state change can commit.
      if (reset) begin
         reqAcquire = '0;
      end
   end

   // Registered ring outputs and arbitration state.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= PASS;
         rrPtr       <= '0;
         owner       <= '0;
         RingOut     <= '0;
         SlotTypeOut <= SLOT_NULL;
         SourceOut   <= '0;
         protoErr    <= 1'b0;
      end else begin
         state       <= nextState;
         rrPtr       <= rrPtrNext;
         owner       <= ownerNext;
         RingOut     <= dataNext;
         SlotTypeOut <= typeNext;
         SourceOut   <= sourceNext;
         protoErr    <= protoErrNext;
      end
   end

endmodule

// File: tb/tb_ring_slot_arbiter.sv
// tb/tb_ring_slot_arbiter.sv - directed vector bench for ring_slot_arbiter
module tb_ring_slot_arbiter;

   localparam int NREQ   = 4;
   localparam int RING_W = 32;
   localparam logic [3:0] TOK  = 4'd1;
   localparam logic [3:0] NUL  = 4'd7;
   localparam logic [3:0] BAR  = 4'd13;
   localparam logic [3:0] CORE = 4'd5;

   logic                   clock;
   logic                   reset;
   logic [3:0]             whichCore;
   logic [RING_W-1:0]      RingIn;
   logic [3:0]             SlotTypeIn;
   logic [3:0]             SourceIn;
   logic [RING_W-1:0]      RingOut;
   logic [3:0]             SlotTypeOut;
   logic [3:0]             SourceOut;
   logic [NREQ-1:0]        reqWants;
   logic [NREQ-1:0]        reqDrive;
   logic [NREQ*RING_W-1:0] reqData;
   logic [NREQ*4-1:0]      reqType;
   logic [NREQ*4-1:0]      reqSource;
   logic [NREQ-1:0]        reqAcquire;
   logic                   protoErr;

   ring_slot_arbiter #(.NREQ(NREQ), .RING_W(RING_W)) dut (
      .clock(clock), .reset(reset), .whichCore(whichCore),
      .RingIn(RingIn), .SlotTypeIn(SlotTypeIn), .SourceIn(SourceIn),
      .RingOut(RingOut), .SlotTypeOut(SlotTypeOut), .SourceOut(SourceOut),
      .reqWants(reqWants), .reqDrive(reqDrive), .reqData(reqData),
      .reqType(reqType), .reqSource(reqSource),
      .reqAcquire(reqAcquire), .protoErr(protoErr)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        rst;
      logic [3:0]  wants;
      logic [3:0]  drive;
      logic [3:0]  typ;
      logic [3:0]  src;
      logic [31:0] data;
      logic [3:0]  expAcq;
      logic [3:0]  expType;
      logic [3:0]  expSrc;
      logic [31:0] expData;
      logic        expErr;
   } vec_t;

   vec_t  vecs[$];
   int    checks = 0;
   int    errors = 0;
   string curName;

   function automatic vec_t mk(input logic rst, input logic [3:0] wants, input logic [3:0] drive,
                               input logic [3:0] typ, input logic [3:0] src, input logic [31:0] data,
                               input logic [3:0] expAcq, input logic [3:0] expType, input logic [3:0] expSrc,
                               input logic [31:0] expData, input logic expErr);
      vec_t v;
      v.rst = rst; v.wants = wants; v.drive = drive; v.typ = typ; v.src = src; v.data = data;
      v.expAcq = expAcq; v.expType = expType; v.expSrc = expSrc; v.expData = expData; v.expErr = expErr;
      return v;
   endfunction

   task automatic chk(input string what, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s %s: got %h expected %h", curName, what, act, exp);
      end
   endtask

   // Called just after a falling edge: drive, check the grant mid-cycle, check registered outputs after the edge.
   task automatic applyVec(input vec_t v);
      reset      = v.rst;
      reqWants   = v.wants;
      reqDrive   = v.drive;
      SlotTypeIn = v.typ;
      SourceIn   = v.src;
      RingIn     = v.data;
      #2;
      chk("reqAcquire", {28'd0, reqAcquire}, {28'd0, v.expAcq});
      @(posedge clock);
      #1;
      chk("SlotTypeOut", {28'd0, SlotTypeOut}, {28'd0, v.expType});
      chk("SourceOut", {28'd0, SourceOut}, {28'd0, v.expSrc});
      chk("RingOut", RingOut, v.expData);
      chk("protoErr", {31'd0, protoErr}, {31'd0, v.expErr});
      @(negedge clock);
   endtask

   initial begin
      whichCore  = CORE;
      reqData    = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
      reqType    = {BAR, BAR, BAR, BAR};
      reqSource  = {CORE, CORE, CORE, CORE};
      reset      = 1'b1;
      reqWants   = '0;
      reqDrive   = '0;
      SlotTypeIn = NUL;
      SourceIn   = '0;
      RingIn     = '0;

      //                 rst wants  drive  type src   data          acq    otype osrc  odata         err
      // reset state
      vecs.push_back(mk(1, 4'h0, 4'h0, NUL, 4'd0, 32'h0,        4'h0, NUL, 4'd0, 32'h0,        0));
      // round robin over three tokens with wants=1011, single-slot senders
      vecs.push_back(mk(0, 4'hB, 4'hB, TOK, 4'd3, 32'h0,        4'h1, BAR, CORE, 32'hA000_0000, 0));
      vecs.push_back(mk(0, 4'hB, 4'h0, NUL, 4'd0, 32'h0,        4'h1, TOK, CORE, 32'h0,        0));
      vecs.push_back(mk(0, 4'hB, 4'hB, TOK, 4'd3, 32'h0,        4'h2, BAR, CORE, 32'hA000_0001, 0));
      vecs.push_back(mk(0, 4'hB, 4'h0, NUL, 4'd0, 32'h0,        4'h2, TOK, CORE, 32'h0,        0));
      vecs.push_back(mk(0, 4'hB, 4'hB, TOK, 4'd3, 32'h0,        4'h8, BAR, CORE, 32'hA000_0003, 0));
      vecs.push_back(mk(0, 4'hB, 4'h0, NUL, 4'd0, 32'h0,        4'h8, TOK, CORE, 32'h0,        0));
      // pointer has wrapped to 0; winner declines to drive so the token passes through
      vecs.push_back(mk(0, 4'hF, 4'h0, TOK, 4'd3, 32'h0,        4'h1, TOK, 4'd3, 32'h0,        0));
      // idle token, foreign message, own returning message, null
      vecs.push_back(mk(0, 4'h0, 4'h0, TOK, 4'd3, 32'h0,        4'h0, TOK, 4'd3, 32'h0,        0));
      vecs.push_back(mk(0, 4'h0, 4'h0, BAR, 4'd2, 32'h1234,     4'h0, BAR, 4'd2, 32'h1234,     0));
      vecs.push_back(mk(0, 4'h0, 4'h0, BAR, CORE, 32'h55,       4'h0, NUL, 4'd0, 32'h0,        0));
      vecs.push_back(mk(0, 4'h0, 4'h0, NUL, 4'd0, 32'h0,        4'h0, NUL, 4'd0, 32'h0,        0));
      // req1 sends one slot: grant same cycle, slot at t1, token at t2
      vecs.push_back(mk(0, 4'h2, 4'h2, TOK, 4'd3, 32'h0,        4'h2, BAR, CORE, 32'hA000_0001, 0));
      vecs.push_back(mk(0, 4'h0, 4'h0, NUL, 4'd0, 32'h0,        4'h2, TOK, CORE, 32'h0,        0));
      vecs.push_back(mk(0, 4'h2, 4'h0, NUL, 4'd0, 32'h0,        4'h0, NUL, 4'd0, 32'h0,        0));

      repeat (2) @(negedge clock);
      foreach (vecs[i]) begin
         curName = $sformatf("vec%0d", i);
         applyVec(vecs[i]);
      end

      // req2 four-slot burst with a foreign message injected mid-burst
      curName = "burst";
      applyVec(mk(0, 4'h4, 4'h4, TOK, 4'd3, 32'h0,    4'h4, BAR, CORE, 32'hA000_0002, 0));
      applyVec(mk(0, 4'h4, 4'h4, NUL, 4'd0, 32'h0,    4'h4, BAR, CORE, 32'hA000_0002, 0));
      applyVec(mk(0, 4'h4, 4'h4, BAR, 4'd2, 32'hBEEF, 4'h4, BAR, CORE, 32'hA000_0002, 1));
      applyVec(mk(0, 4'h4, 4'h4, NUL, 4'd0, 32'h0,    4'h4, BAR, CORE, 32'hA000_0002, 1));
      applyVec(mk(0, 4'h4, 4'h0, NUL, 4'd0, 32'h0,    4'h4, TOK, CORE, 32'h0,        1));
      applyVec(mk(0, 4'h0, 4'h0, NUL, 4'd0, 32'h0,    4'h0, NUL, 4'd0, 32'h0,        1));

      // reset while req0 holds the token; afterwards a non-token cycle must show no grant
      curName = "resetHold";
      applyVec(mk(0, 4'h1, 4'h1, TOK, 4'd3, 32'h0,    4'h1, BAR, CORE, 32'hA000_0000, 1));
      applyVec(mk(1, 4'h1, 4'h1, TOK, 4'd3, 32'h0,    4'h0, NUL, 4'd0, 32'h0,        0));
      applyVec(mk(0, 4'h0, 4'h1, NUL, 4'd0, 32'h0,    4'h0, NUL, 4'd0, 32'h0,        0));

      // duplicate token arriving while held is dropped and flagged
      curName = "dupToken";
      applyVec(mk(0, 4'h1, 4'h1, TOK, 4'd3, 32'h0,    4'h1, BAR, CORE, 32'hA000_0000, 0));
      applyVec(mk(0, 4'h1, 4'h1, TOK, 4'd3, 32'h0,    4'h1, BAR, CORE, 32'hA000_0000, 1));
      applyVec(mk(0, 4'h0, 4'h0, NUL, 4'd0, 32'h0,    4'h1, TOK, CORE, 32'h0,        1));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
